// File: rtl/min_delay_pipe.sv
// min_delay_pipe: CHANNELS independent WIDTH-bit lanes carried through a DEPTH-stage
// stallable register pipeline with valid/ready handshakes. Each lane can optionally
// AND its input with a registered, inverted copy of its previously loaded value.
// This gives a long, flop-dense register-to-register path with a reconvergent
// feedback net.

module min_delay_pipe #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned FEEDBACK = 1
) (
  input  logic                         clk1,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*WIDTH-1:0]    in_data,
  input  logic                         fb_enable,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*WIDTH-1:0]    out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned BusW = CHANNELS * WIDTH;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [DEPTH-1:0] adv;
  logic [BusW-1:0]  data_q [DEPTH];
  logic [BusW-1:0]  fb_q;
  logic [BusW-1:0]  d0;
  logic [CntW-1:0]  count_q;
  logic [CntW-1:0]  count_d;
  logic             accept;
  logic             fb_active;

  // With FEEDBACK=0 this folds to constant 0, so fb_enable has no effect.
  assign fb_active = (FEEDBACK != 0) & fb_enable;

  assign in_ready  = ~v_q[0] | adv[0];
  assign accept    = in_valid & in_ready;
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign count     = count_q;

  // Stage-0 load value, computed lane by lane so no bit crosses a lane boundary.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    assign d0[c*WIDTH +: WIDTH] = fb_active ? (in_data[c*WIDTH +: WIDTH] & fb_q[c*WIDTH +: WIDTH])
                                            : in_data[c*WIDTH +: WIDTH];
  end

  // Advance chain: ready ripples combinationally from the output back so bubbles collapse.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = v_q[DEPTH-1] & out_ready;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      adv[k] = v_q[k] & (~v_q[k+1] | adv[k+1]);
    end
  end

  // Next-state valid bits and occupancy count (popcount of the next valid vector).
  always_comb begin
    v_d     = v_q;
    count_d = '0;
    v_d[0]  = accept | (v_q[0] & ~adv[0]);
    for (int k = 1; k < DEPTH; k++) begin
      v_d[k] = adv[k-1] | (v_q[k] & ~adv[k]);
    end
    for (int k = 0; k < DEPTH; k++) begin
      count_d = count_d + CntW'(v_d[k]);
    end
  end

  // Valid bits and count register.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      v_q     <= '0;
      count_q <= '0;
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
    end
  end

  // Data registers: load only on a move so an emptied stage keeps its last value.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      if (accept) begin
        data_q[0] <= d0;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (adv[k-1]) begin
          data_q[k] <= data_q[k-1];
        end
      end
    end
  end

  // Feedback register: captures the inverted stage-0 load value on each feedback accept.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      fb_q <= '1;
    end else if (accept && fb_active) begin
      fb_q <= ~d0;
    end
  end

endmodule

// File: tb/tb_min_delay_pipe.sv
// Self-checking bench for min_delay_pipe (WIDTH=8, DEPTH=4, CHANNELS=2, FEEDBACK=1).
// Accepted words push their expected output into a queue; a monitor pops and compares
// on every output transfer.

module tb_min_delay_pipe;

  logic        clk1;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        fb_enable;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  count;

  logic [15:0] exp_q [$];
  logic [15:0] mon_exp;
  int          n_vec;
  int          n_err;

  min_delay_pipe #(
    .WIDTH   (8),
    .DEPTH   (4),
    .CHANNELS(2),
    .FEEDBACK(1)
  ) dut (
    .clk1     (clk1),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .fb_enable(fb_enable),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  // Pulse reset; returns one time unit after the release edge.
  task automatic apply_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    fb_enable = 1'b0;
    in_data   = '0;
    @(posedge clk1);
    #1 rst = 1'b1;
    @(posedge clk1);
    #1 rst = 1'b0;
    exp_q.delete();
  endtask

  // Offer one word and wait (bounded) for it to be accepted; e is the expected output.
  task automatic send(input logic [15:0] w, input logic fbe, input logic [15:0] e);
    int n;
    n         = 0;
    in_valid  = 1'b1;
    in_data   = w;
    fb_enable = fbe;
    @(negedge clk1);
    while (!in_ready && n < 64) begin
      @(negedge clk1);
      n++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: in_ready=%b required=1 word=%h", in_ready, w);
      in_valid = 1'b0;
    end else begin
      @(posedge clk1);
      exp_q.push_back(e);
      #1 in_valid = 1'b0;
    end
  endtask

  // Let everything out and confirm the pipe empties.
  task automatic drain();
    int n;
    n         = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 64) begin
      @(posedge clk1);
      n++;
    end
    #1;
    n_vec++;
    if (exp_q.size() != 0 || out_valid !== 1'b0 || count !== 3'd0) begin
      n_err++;
      $display("FAIL drain: pending=%0d out_valid=%b count=%0d required 0/0/0",
               exp_q.size(), out_valid, count);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out_valid: got=%b required=0", out_valid);
    end
    n_vec++;
    if (out_data !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_out_data: got=%h required=0000", out_data);
    end
    n_vec++;
    if (count !== 3'd0) begin
      n_err++;
      $display("FAIL reset_count: got=%0d required=0", count);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got=%b required=1", in_ready);
    end
  endtask

  task automatic test_passthrough();
    apply_reset();
    out_ready = 1'b1;
    send(16'h1122, 1'b0, 16'h1122);
    send(16'h3344, 1'b0, 16'h3344);
    send(16'h5566, 1'b0, 16'h5566);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL latency_early: out_valid=%b required=0", out_valid);
    end
    @(posedge clk1);
    #1;
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 16'h1122) begin
      n_err++;
      $display("FAIL latency_first: out_valid=%b out_data=%h required 1/1122", out_valid,
               out_data);
    end
    @(posedge clk1);
    #1;
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 16'h3344) begin
      n_err++;
      $display("FAIL latency_second: out_valid=%b out_data=%h required 1/3344", out_valid,
               out_data);
    end
    drain();
  endtask

  task automatic test_feedback();
    apply_reset();
    out_ready = 1'b1;
    // Lane 0: F0,FF,FF -> F0,0F,F0. Lane 1: AA,FF,FF -> AA,55,AA.
    send(16'hAAF0, 1'b1, 16'hAAF0);
    send(16'hFFFF, 1'b1, 16'h550F);
    send(16'hFFFF, 1'b1, 16'hAAF0);
    drain();
  endtask

  task automatic test_backpressure();
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(16'hC0D0 + 16'(i), 1'b0, 16'hC0D0 + 16'(i));
    end
    in_valid  = 1'b1;
    in_data   = 16'hC0D4;
    fb_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk1);
      n_vec++;
      if (in_ready !== 1'b0 || count !== 3'd4 || out_valid !== 1'b1 || out_data !== 16'hC0D0)
      begin
        n_err++;
        $display("FAIL stall_hold: in_ready=%b count=%0d out_valid=%b out_data=%h required 0/4/1/c0d0",
                 in_ready, count, out_valid, out_data);
      end
    end
    @(posedge clk1);
    #1 out_ready = 1'b1;
    @(negedge clk1);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL full_pass_through_ready: in_ready=%b required=1", in_ready);
    end
    @(posedge clk1);
    exp_q.push_back(16'hC0D4);
    #1 in_valid = 1'b0;
    n_vec++;
    if (count !== 3'd4) begin
      n_err++;
      $display("FAIL full_accept_emit_count: count=%0d required=4", count);
    end
    send(16'hC0D5, 1'b0, 16'hC0D5);
    drain();
  endtask

  task automatic test_bubble();
    apply_reset();
    out_ready = 1'b0;
    send(16'h1A1B, 1'b0, 16'h1A1B);
    repeat (2) @(posedge clk1);
    #1;
    send(16'h2A2B, 1'b0, 16'h2A2B);
    repeat (3) @(posedge clk1);
    #1;
    n_vec++;
    if (count !== 3'd2 || out_valid !== 1'b1 || out_data !== 16'h1A1B || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bubble_packed: count=%0d out_valid=%b out_data=%h in_ready=%b required 2/1/1a1b/1",
               count, out_valid, out_data, in_ready);
    end
    out_ready = 1'b1;
    @(posedge clk1);
    #1;
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 16'h2A2B) begin
      n_err++;
      $display("FAIL bubble_follow: out_valid=%b out_data=%h required 1/2a2b", out_valid,
               out_data);
    end
    drain();
  endtask

  task automatic test_async_reset();
    apply_reset();
    out_ready = 1'b0;
    send(16'h3C3C, 1'b1, 16'h0000);
    send(16'h1111, 1'b1, 16'h0000);
    send(16'h2222, 1'b1, 16'h0000);
    n_vec++;
    if (count !== 3'd3) begin
      n_err++;
      $display("FAIL inflight_count: count=%0d required=3", count);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      n_err++;
      $display("FAIL async_reset: out_valid=%b count=%0d required 0/0", out_valid, count);
    end
    exp_q.delete();
    @(posedge clk1);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    send(16'hF0F0, 1'b1, 16'hF0F0);
    drain();
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    fb_enable = 1'b0;
    out_ready = 1'b0;
    fork
      // Scoreboard monitor: compare every output transfer against the queue head.
      forever begin
        @(negedge clk1);
        if (!rst && out_valid && out_ready) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_extra: out_data=%h with no word expected", out_data);
          end else begin
            mon_exp = exp_q.pop_front();
            if (out_data !== mon_exp) begin
              n_err++;
              $display("FAIL scoreboard_data: out_data=%h required=%h", out_data, mon_exp);
            end
          end
        end
      end
      begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
      end
    join_none
    test_reset();
    test_passthrough();
    test_feedback();
    test_backpressure();
    test_bubble();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
